// File: rtl/arch_mem_pkg.sv
// Shared memory-architecture definitions: arbiter state encoding,
// wishbone cycle-type identifiers and the default DMA burst length.
package arch_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CPU  = 2'd1,
        ST_VID  = 2'd2,
        ST_SND  = 2'd3
    } arb_state_t;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam int DEFAULT_BURST_LEN = 4;

endpackage

// File: rtl/dma_beat_ctr.sv
// Beat index within a DMA burst; wraps to zero on the acknowledged last beat.
module dma_beat_ctr
    import arch_mem_pkg::*;
#(
    parameter int BURST_LEN = DEFAULT_BURST_LEN,
    parameter int BEAT_W    = $clog2(BURST_LEN)
) (
    input  logic              clkcpu,
    input  logic              rst_n,
    input  logic              advance,
    output logic [BEAT_W-1:0] beat,
    output logic              last
);

    assign last = (beat == BEAT_W'(BURST_LEN - 1));

    always_ff @(posedge clkcpu or negedge rst_n) begin
        if (!rst_n) begin
            beat <= '0;
        end else if (advance) begin
            beat <= last ? '0 : beat + 1'b1;
        end
    end

endmodule

// File: rtl/dma_arbiter.sv
// Shared-memory arbiter for CPU, video DMA and sound DMA wishbone masters.
// Optional macro CPU_STARVE_GUARD_EN lets a waiting CPU win after two DMA bursts.
module dma_arbiter
    import arch_mem_pkg::*;
#(
    parameter int BURST_LEN = DEFAULT_BURST_LEN
) (
    input  logic        clkcpu,
    input  logic        rst_n,
    input  logic        cpu_cyc,
    input  logic        cpu_stb,
    input  logic        cpu_we,
    input  logic [3:0]  cpu_sel,
    input  logic [21:0] cpu_adr,
    output logic        cpu_ack,
    input  logic        vid_req,
    input  logic [21:0] vid_adr,
    output logic        vid_ack,
    input  logic        snd_req,
    input  logic [21:0] snd_adr,
    output logic        snd_ack,
    output logic        mem_cyc_o,
    output logic        mem_stb_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_sel_o,
    output logic [2:0]  mem_cti_o,
    output logic [21:0] mem_adr_o,
    input  logic        mem_ack_i
);

    localparam int BEAT_W = $clog2(BURST_LEN);

    arb_state_t        state;
    arb_state_t        state_nxt;
    logic [21:0]       lat_adr;
    logic [3:0]        lat_sel;
    logic              lat_we;
    logic              armed;
    logic [BEAT_W-1:0] beat;
    logic              last_beat;
    logic              beat_adv;
    logic              cpu_pend;
    logic              cpu_first;

    assign cpu_pend = cpu_cyc & cpu_stb;
    assign beat_adv = ((state == ST_VID) || (state == ST_SND)) && mem_ack_i;

    dma_beat_ctr #(
        .BURST_LEN (BURST_LEN),
        .BEAT_W    (BEAT_W)
    ) u_beat_ctr (
        .clkcpu  (clkcpu),
        .rst_n   (rst_n),
        .advance (beat_adv),
        .beat    (beat),
        .last    (last_beat)
    );

`ifdef CPU_STARVE_GUARD_EN
    logic [1:0] starve_cnt;

    // Counts DMA bursts that finished while the CPU was kept waiting.
    always_ff @(posedge clkcpu or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if ((state == ST_IDLE) && (state_nxt == ST_CPU)) begin
            starve_cnt <= '0;
        end else if (beat_adv && last_beat && cpu_pend && (starve_cnt != 2'd3)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    assign cpu_first = cpu_pend && (starve_cnt >= 2'd2);
`else
    assign cpu_first = 1'b0;
`endif

    // armed holds off arbitration for the first edge after reset release.
    always_ff @(posedge clkcpu or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            armed   <= 1'b0;
            lat_adr <= '0;
            lat_sel <= '0;
            lat_we  <= 1'b0;
        end else begin
            state <= state_nxt;
            armed <= 1'b1;
            if (state == ST_IDLE) begin
                case (state_nxt)
                    ST_CPU: begin
                        lat_adr <= cpu_adr;
                        lat_sel <= cpu_sel;
                        lat_we  <= cpu_we;
                    end
                    ST_VID:  lat_adr <= vid_adr;
                    ST_SND:  lat_adr <= snd_adr;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        state_nxt = state;
        mem_cyc_o = 1'b0;
        mem_stb_o = 1'b0;
        mem_we_o  = 1'b0;
        mem_sel_o = 4'h0;
        mem_cti_o = CTI_CLASSIC;
        mem_adr_o = '0;
        cpu_ack   = 1'b0;
        vid_ack   = 1'b0;
        snd_ack   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (armed) begin
                    if (cpu_first)     state_nxt = ST_CPU;
                    else if (vid_req)  state_nxt = ST_VID;
                    else if (snd_req)  state_nxt = ST_SND;
                    else if (cpu_pend) state_nxt = ST_CPU;
                end
            end
            ST_CPU: begin
                mem_cyc_o = 1'b1;
                mem_stb_o = 1'b1;
                mem_we_o  = lat_we;
                mem_sel_o = lat_sel;
                mem_adr_o = lat_adr;
                cpu_ack   = mem_ack_i & cpu_stb;
                if (mem_ack_i) state_nxt = ST_IDLE;
            end
            ST_VID, ST_SND: begin
                mem_cyc_o = 1'b1;
                mem_stb_o = 1'b1;
                mem_sel_o = 4'hF;
                mem_cti_o = last_beat ? CTI_EOB : CTI_INCR;
                mem_adr_o = lat_adr + 22'(beat);
                vid_ack   = mem_ack_i & (state == ST_VID);
                snd_ack   = mem_ack_i & (state == ST_SND);
                if (mem_ack_i && last_beat) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: doc/dma_arbiter.md
DMA_ARBITER -- requirements
Module: dma_arbiter

Interface
REQ-001 SHALL have parameter BURST_LEN, default 4, meaning words per DMA burst (legal values 2, 4, 8).
REQ-002 SHALL have port clkcpu  in  1  system clock; all logic on rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports cpu_cyc, cpu_stb, cpu_we  in  1 each  CPU wishbone request qualifiers.
REQ-005 SHALL have ports cpu_sel  in  4 and cpu_adr  in  22 ([23:2]), the CPU byte lanes and word address.
REQ-006 SHALL have port cpu_ack  out  1  CPU transfer complete.
REQ-007 SHALL have ports vid_req  in  1, vid_adr  in  22 and vid_ack  out  1: video DMA request, burst start address, per-beat acknowledge.
REQ-008 SHALL have ports snd_req  in  1, snd_adr  in  22 and snd_ack  out  1: sound DMA request, burst start address, per-beat acknowledge.
REQ-009 SHALL have ports mem_cyc_o, mem_stb_o, mem_we_o  out  1 each; mem_sel_o  out  4; mem_cti_o  out  3; mem_adr_o  out  22; mem_ack_i  in  1. These form the shared memory wishbone master port.

Function
REQ-010 SHALL implement states IDLE, CPU, VID, SND; it leaves IDLE only on a pending request.
REQ-011 SHALL arbitrate in IDLE only, with fixed priority vid_req > snd_req > (cpu_cyc & cpu_stb).
REQ-012 SHALL register the grant: requests sampled in IDLE at edge N put mem_cyc_o/mem_stb_o high from edge N+1.
REQ-013 SHALL latch address, sel and we at grant; later changes on requester inputs have no effect until IDLE.
REQ-014 CPU state: single beat, mem_cti_o=3'b000, mem_sel_o=cpu_sel, mem_we_o=cpu_we, cpu_ack=mem_ack_i combinationally.
REQ-015 VID/SND state: read burst of BURST_LEN beats, mem_we_o=0, mem_sel_o=4'hF.
REQ-016 VID/SND state: mem_adr_o = latched start + beat index, modulo 2^22 (wraps at 0x3FFFFF→0).
REQ-017 VID/SND state: mem_cti_o=3'b010 for beats 0..BURST_LEN-2 and 3'b111 on the last beat.
REQ-018 SHALL make vid_ack/snd_ack equal mem_ack_i while in VID/SND respectively, else 0; exactly BURST_LEN pulses per burst.
REQ-019 SHALL complete a granted burst even if its request drops mid-burst; no early termination.
REQ-020 On the final mem_ack_i it SHALL return to IDLE with mem_cyc_o/mem_stb_o low for at least one cycle before the next grant.
REQ-021 SHALL hold state with outputs stable while mem_ack_i is low; there is no timeout.
REQ-022 cpu_ack SHALL never assert outside CPU state, and never when cpu_stb is low.
REQ-023 SHALL not route data buses; read/write data flows externally on the shared memory data bus.

Reset
REQ-024 rst_n low SHALL force IDLE, beat counter 0 and all outputs 0, asynchronously, including mid-burst.
REQ-025 After rst_n rises, the first grant SHALL occur no earlier than the second rising edge.

Configuration
REQ-026 SHALL support macro CPU_STARVE_GUARD_EN.
REQ-027 With CPU_STARVE_GUARD_EN defined: a 2-bit counter increments per completed DMA burst while a CPU request is pending, and clears on a CPU grant.
REQ-028 With CPU_STARVE_GUARD_EN defined: at count 2, a pending CPU request wins the next arbitration over vid and snd.
REQ-029 Without CPU_STARVE_GUARD_EN: strict priority per REQ-011, no counter logic synthesized.

Structure
REQ-030 SHALL take the state encoding, CTI constants (CLASSIC=3'b000, INCR=3'b010, EOB=3'b111) and default BURST_LEN from shared package arch_mem_pkg.
REQ-031 SHALL place beat counting and last-beat detection in sub-module dma_beat_ctr; arbitration and output muxing stay in dma_arbiter.

Verification
REQ-032 vid_req=1, vid_adr=0x001000, ack every cycle -> mem_adr_o 0x001000..0x001003, cti 010,010,010,111, four vid_ack, then IDLE.
REQ-033 vid_req, snd_req and CPU request asserted together -> VID burst, IDLE, SND burst, IDLE, then the CPU beat; cpu_ack exactly once.
REQ-034 snd_adr=0x3FFFFE -> addresses 0x3FFFFE, 0x3FFFFF, 0x000000, 0x000001.
REQ-035 rst_n low after second beat of VID burst -> mem_cyc_o=0 and vid_ack=0 immediately; after release a new vid_req starts again at beat 0.
REQ-036 CPU write, cpu_sel=4'b0100, mem_ack_i delayed 5 cycles -> outputs stable for 5 cycles, mem_we_o=1, mem_sel_o=4'b0100, single cpu_ack.
REQ-037 With CPU_STARVE_GUARD_EN, vid_req held and CPU pending -> CPU granted after the second VID burst; without the macro, the CPU is never granted while vid_req is held.
